// File: rtl/dcache_wb_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
`timescale 1ns/1ps
package dcache_wb_pkg;
  localparam int DC_WD_SIZE    = 32;
  localparam int DC_LINES      = 4;
  localparam int DC_LINE_BYTES = 16;
  localparam int DC_IDX_BITS   = $clog2(DC_LINES);
  localparam int DC_OFF_BITS   = $clog2(DC_LINE_BYTES);
  localparam int DC_TAG_BITS   = DC_WD_SIZE - DC_IDX_BITS - DC_OFF_BITS;

  typedef enum logic [1:0] {
    DC_IDLE,
    DC_EVICT,
    DC_FILL,
    DC_RETRY
  } dc_state_t;
endpackage

// File: rtl/dcache_line_merge.sv
// Word select out of a cache line and keep-masked store merge back into that line.
`timescale 1ns/1ps
module dcache_line_merge
  import dcache_wb_pkg::*;
#(
  parameter int WD_SIZE    = DC_WD_SIZE,
  parameter int LINE_BYTES = DC_LINE_BYTES,
  parameter int WIDX_W     = (DC_OFF_BITS > 2) ? DC_OFF_BITS - 2 : 1
) (
  input  logic [LINE_BYTES*8-1:0] line,
  input  logic [WIDX_W-1:0]       word_idx,
  input  logic [WD_SIZE-1:0]      wr_data,
  input  logic [WD_SIZE-1:0]      keep,
  output logic [WD_SIZE-1:0]      rd_word,
  output logic [LINE_BYTES*8-1:0] merged_line
);
  always_comb begin
    rd_word     = line[word_idx*WD_SIZE +: WD_SIZE];
    merged_line = line;
    merged_line[word_idx*WD_SIZE +: WD_SIZE] = (rd_word & ~keep) | (wr_data & keep);
  end
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache; hits are zero-cycle, misses
// stall the core while a line is evicted (if dirty) and refilled.
`timescale 1ns/1ps
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int WD_SIZE    = DC_WD_SIZE,
  parameter int LINES      = DC_LINES,
  parameter int LINE_BYTES = DC_LINE_BYTES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_en_i,
  input  logic                    req_rd_wr_i,
  input  logic [WD_SIZE-1:0]      req_addr_i,
  input  logic [WD_SIZE-1:0]      req_wr_data_i,
  input  logic [WD_SIZE-1:0]      req_wr_keep_i,
  output logic [WD_SIZE-1:0]      rd_data_o,
  output logic                    stall_o,
  output logic                    mem_req_o,
  output logic                    mem_rd_wr_o,
  output logic [WD_SIZE-1:0]      mem_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_wr_line_o,
  input  logic [LINE_BYTES*8-1:0] mem_rd_line_i,
  input  logic                    mem_ack_i
);
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = WD_SIZE - IDX_W - OFF_W;
  localparam int WIDX_W = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int LINE_W = LINE_BYTES * 8;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [WD_SIZE-1:0] rd_data_q;
  dc_state_t state_q, state_d;

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   idx;
  logic [WIDX_W-1:0]  word_idx;
  logic               hit;
  logic               rd_hit, wr_hit, evict_done, fill_done, stall_c;
  logic [WD_SIZE-1:0] rd_word;
  logic [LINE_W-1:0]  wr_line;
  logic               unused_addr_lsbs;

  assign req_tag = req_addr_i[WD_SIZE-1 -: TAG_W];
  assign idx     = req_addr_i[OFF_W +: IDX_W];
  assign unused_addr_lsbs = ^req_addr_i[1:0];

  // A line of a single word has no word index field.
  generate
    if (OFF_W > 2) begin : g_widx
      assign word_idx = req_addr_i[OFF_W-1:2];
    end else begin : g_nowidx
      assign word_idx = '0;
    end
  endgenerate

  assign hit = req_en_i & valid_q[idx] & (tag_q[idx] == req_tag);

  dcache_line_merge #(
    .WD_SIZE    (WD_SIZE),
    .LINE_BYTES (LINE_BYTES),
    .WIDX_W     (WIDX_W)
  ) u_merge (
    .line        (data_q[idx]),
    .word_idx    (word_idx),
    .wr_data     (req_wr_data_i),
    .keep        (req_wr_keep_i),
    .rd_word     (rd_word),
    .merged_line (wr_line)
  );

  always_comb begin
    state_d       = state_q;
    stall_c       = 1'b1;
    rd_hit        = 1'b0;
    wr_hit        = 1'b0;
    evict_done    = 1'b0;
    fill_done     = 1'b0;
    mem_req_o     = 1'b0;
    mem_rd_wr_o   = 1'b0;
    mem_addr_o    = '0;
    mem_wr_line_o = '0;
    unique case (state_q)
      DC_IDLE: begin
        stall_c = req_en_i & ~hit;
        rd_hit  = hit & ~req_rd_wr_i;
        wr_hit  = hit & req_rd_wr_i;
        if (req_en_i && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? DC_EVICT : DC_FILL;
        end
      end
      DC_EVICT: begin
        mem_req_o     = 1'b1;
        mem_rd_wr_o   = 1'b1;
        mem_addr_o    = {tag_q[idx], idx, {OFF_W{1'b0}}};
        mem_wr_line_o = data_q[idx];
        if (mem_ack_i) begin
          evict_done = 1'b1;
          state_d    = DC_FILL;
        end
      end
      DC_FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, idx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          fill_done = 1'b1;
          state_d   = DC_RETRY;
        end
      end
      DC_RETRY: state_d = DC_IDLE;
      default:  state_d = DC_IDLE;
    endcase
  end

  // Gating with reset_n keeps the core free while the cache is being cleared.
  assign stall_o   = reset_n & stall_c;
  assign rd_data_o = rd_hit ? rd_word : rd_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DC_IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_hit)     rd_data_q    <= rd_word;
      if (wr_hit)     dirty_q[idx] <= 1'b1;
      if (evict_done) dirty_q[idx] <= 1'b0;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_hit) data_q[idx] <= wr_line;
    if (fill_done) begin
      data_q[idx] <= mem_rd_line_i;
      tag_q[idx]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: vector table with scoreboard plus reset/ack corner sequences.
`timescale 1ns/1ps
module tb_dcache_wb;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_en_i = 1'b0;
  logic          req_rd_wr_i = 1'b0;
  logic [31:0]   req_addr_i = '0;
  logic [31:0]   req_wr_data_i = '0;
  logic [31:0]   req_wr_keep_i = '0;
  logic [31:0]   rd_data_o;
  logic          stall_o;
  logic          mem_req_o;
  logic          mem_rd_wr_o;
  logic [31:0]   mem_addr_o;
  logic [LW-1:0] mem_wr_line_o;
  logic [LW-1:0] mem_rd_line_i = '0;
  logic          mem_ack_i = 1'b0;

  always #5 clk = ~clk;

  dcache_wb #(.WD_SIZE(32), .LINES(4), .LINE_BYTES(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_en_i      (req_en_i),
    .req_rd_wr_i   (req_rd_wr_i),
    .req_addr_i    (req_addr_i),
    .req_wr_data_i (req_wr_data_i),
    .req_wr_keep_i (req_wr_keep_i),
    .rd_data_o     (rd_data_o),
    .stall_o       (stall_o),
    .mem_req_o     (mem_req_o),
    .mem_rd_wr_o   (mem_rd_wr_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_line_o (mem_wr_line_o),
    .mem_rd_line_i (mem_rd_line_i),
    .mem_ack_i     (mem_ack_i)
  );

  typedef struct {
    logic        rd_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] keep;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_evict;
    int          exp_fill;
  } vec_t;

  typedef struct {
    string       name;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    int          exp_stall;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  // Backing memory model
  logic [LW-1:0] mem_model [logic [31:0]];
  bit            mem_auto = 1'b1;
  bit            force_ack = 1'b0;
  logic [LW-1:0] force_line = '0;
  int            ack_lat = 3;
  int            req_cyc = 0;
  int            evict_cnt = 0;
  int            fill_cnt = 0;
  int            unstable = 0;
  logic [31:0]   last_evict_addr = '0;
  logic [31:0]   last_fill_addr = '0;
  logic [LW-1:0] last_evict_line = '0;
  logic [31:0]   held_addr = '0;
  logic [LW-1:0] held_line = '0;
  logic          held_rw = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (!mem_auto) begin
      mem_ack_i     = force_ack;
      mem_rd_line_i = force_line;
    end else begin
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        req_cyc++;
        if (req_cyc == 1) begin
          held_addr = mem_addr_o;
          held_line = mem_wr_line_o;
          held_rw   = mem_rd_wr_o;
        end else if (mem_addr_o !== held_addr || mem_wr_line_o !== held_line ||
                     mem_rd_wr_o !== held_rw) begin
          unstable++;
        end
        if (req_cyc >= ack_lat) begin
          mem_ack_i = 1'b1;
          req_cyc   = 0;
          if (mem_rd_wr_o) begin
            evict_cnt++;
            last_evict_addr = mem_addr_o;
            last_evict_line = mem_wr_line_o;
            mem_model[mem_addr_o] = mem_wr_line_o;
          end else begin
            fill_cnt++;
            last_fill_addr = mem_addr_o;
            mem_rd_line_i  = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : '0;
          end
        end
      end else begin
        req_cyc = 0;
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; the request stays up until stall_o is low.
  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] keep);
    sb_t e;
    int  cyc;
    bit  done;
    req_en_i      = 1'b1;
    req_rd_wr_i   = rw;
    req_addr_i    = addr;
    req_wr_data_i = wdata;
    req_wr_keep_i = keep;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!stall_o || cyc > 60) begin
        e = sb_q.pop_front();
        check32({e.name, "_stall_cycles"}, 32'(cyc), 32'(e.exp_stall));
        if (e.chk_rd) check32({e.name, "_rdata"}, rd_data_o, e.exp_rdata);
        done = 1'b1;
      end else begin
        cyc++;
      end
      @(posedge clk);
      #1;
    end
    req_en_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    sb_t e;
    int  ev0, fl0;
    e.name      = name;
    e.chk_rd    = ~v.rd_wr;
    e.exp_rdata = v.exp_rdata;
    e.exp_stall = v.exp_stall;
    sb_q.push_back(e);
    ev0 = evict_cnt;
    fl0 = fill_cnt;
    do_req(v.rd_wr, v.addr, v.wdata, v.keep);
    check32({name, "_evicts"}, 32'(evict_cnt - ev0), 32'(v.exp_evict));
    check32({name, "_fills"}, 32'(fill_cnt - fl0), 32'(v.exp_fill));
    if (v.exp_fill != 0) check32({name, "_fill_addr"}, last_fill_addr, v.addr & ~32'hF);
  endtask

  vec_t tbl[13];
  vec_t v;

  initial begin
    mem_model[32'h00] = {32'h33334444, 32'h11112222, 32'hAABBCCDD, 32'hDEADBEEF};
    mem_model[32'h10] = {32'h13131313, 32'h12121212, 32'h11111111, 32'h10101010};
    mem_model[32'h20] = {32'h23232323, 32'h22222222, 32'h21212121, 32'h20202020};
    mem_model[32'h30] = {32'h33333333, 32'h32323232, 32'h31313131, 32'h30303030};
    mem_model[32'h40] = {32'h43434343, 32'h42424242, 32'h41414141, 32'h40404040};

    //            rd_wr addr    wdata         keep          exp_rdata    stall ev fill
    tbl[0]  = '{1'b0, 32'h00, 32'h0,        32'h0,        32'hDEADBEEF, 5, 0, 1};
    tbl[1]  = '{1'b0, 32'h04, 32'h0,        32'h0,        32'hAABBCCDD, 0, 0, 0};
    tbl[2]  = '{1'b1, 32'h04, 32'h12345678, 32'h0000FFFF, 32'h0,        0, 0, 0};
    tbl[3]  = '{1'b0, 32'h04, 32'h0,        32'h0,        32'hAABB5678, 0, 0, 0};
    tbl[4]  = '{1'b0, 32'h10, 32'h0,        32'h0,        32'h10101010, 5, 0, 1};
    tbl[5]  = '{1'b0, 32'h40, 32'h0,        32'h0,        32'h40404040, 8, 1, 1};
    tbl[6]  = '{1'b0, 32'h04, 32'h0,        32'h0,        32'hAABB5678, 5, 0, 1};
    tbl[7]  = '{1'b1, 32'h2C, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0,        5, 0, 1};
    tbl[8]  = '{1'b0, 32'h2C, 32'h0,        32'h0,        32'hFFFF0000, 0, 0, 0};
    tbl[9]  = '{1'b1, 32'h08, 32'h000000A5, 32'h000000FF, 32'h0,        0, 0, 0};
    tbl[10] = '{1'b0, 32'h08, 32'h0,        32'h0,        32'h111122A5, 0, 0, 0};
    tbl[11] = '{1'b0, 32'h10, 32'h0,        32'h0,        32'h10101010, 0, 0, 0};
    tbl[12] = '{1'b0, 32'h20, 32'h0,        32'h0,        32'h20202020, 0, 0, 0};

    #12;
    check32("rst_stall", 32'(stall_o), 32'h0);
    check32("rst_mem_req", 32'(mem_req_o), 32'h0);
    check32("rst_mem_rd_wr", 32'(mem_rd_wr_o), 32'h0);
    check32("rst_mem_addr", mem_addr_o, 32'h0);
    check128("rst_mem_wr_line", mem_wr_line_o, '0);
    check32("rst_rd_data", rd_data_o, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    check32("evict_addr", last_evict_addr, 32'h00);
    check128("evict_line", last_evict_line,
             {32'h33334444, 32'h11112222, 32'hAABB5678, 32'hDEADBEEF});
    check32("mem_hold_stable", 32'(unstable), 32'h0);

    // Stray ack while idle with a hit pending must change nothing.
    mem_auto   = 1'b0;
    force_ack  = 1'b1;
    force_line = {4{32'hF0F0F0F0}};
    @(posedge clk);
    #1;
    sb_q.push_back('{"ack_idle_hit", 1'b1, 32'h10101010, 0});
    do_req(1'b0, 32'h10, 32'h0, 32'h0);
    force_ack = 1'b0;
    check32("ack_idle_mem_req", 32'(mem_req_o), 32'h0);
    sb_q.push_back('{"ack_idle_after", 1'b1, 32'h11111111, 0});
    do_req(1'b0, 32'h14, 32'h0, 32'h0);
    mem_auto = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted in the middle of a fill.
    ack_lat     = 10;
    req_en_i    = 1'b1;
    req_rd_wr_i = 1'b0;
    req_addr_i  = 32'h30;
    @(negedge clk);
    check32("rf_miss_stall", 32'(stall_o), 32'h1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check32("rf_fill_req", 32'(mem_req_o), 32'h1);
    check32("rf_fill_rd_wr", 32'(mem_rd_wr_o), 32'h0);
    check32("rf_fill_addr", mem_addr_o, 32'h30);
    #2;
    reset_n = 1'b0;
    #1;
    check32("rf_rst_mem_req", 32'(mem_req_o), 32'h0);
    check32("rf_rst_stall", 32'(stall_o), 32'h0);
    check32("rf_rst_mem_addr", mem_addr_o, 32'h0);
    req_en_i = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ack_lat = 3;
    @(posedge clk);
    #1;
    v = '{1'b0, 32'h08, 32'h0, 32'h0, 32'h11112222, 5, 0, 1};
    run_vec(v, "post_rst_line0");
    v = '{1'b0, 32'h10, 32'h0, 32'h0, 32'h10101010, 5, 0, 1};
    run_vec(v, "post_rst_line1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
